// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: a prescaled step tick advances a selectable
// 8-bit pattern (static/chase/bounce/count), then global PWM brightness.
module led_pattern_sequencer #(
  parameter int unsigned STEP_DIV = 1200000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [1:0]          mode_in,
  input  logic                mode_load,
  input  logic [PWM_BITS-1:0] duty,
  output logic [7:0]          leds,
  output logic                step_tick,
  output logic                cycle_done,
  output logic [1:0]          cur_mode,
  output logic                mode_pending
);

  typedef enum logic [1:0] {STATIC = 2'd0, CHASE = 2'd1, BOUNCE = 2'd2, COUNT = 2'd3} mode_t;
  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} dir_t;

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0]       pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [7:0]          pattern;
  dir_t                dir;
  mode_t               mode_q, pend_q;

  logic       step, req, wrap, pwm_on;
  mode_t      req_mode;
  logic [7:0] adv_pat;
  dir_t       adv_dir;

  function automatic logic [7:0] start_val(input mode_t m);
    case (m)
      STATIC:  start_val = 8'hFF;
      CHASE:   start_val = 8'h01;
      BOUNCE:  start_val = 8'h01;
      default: start_val = 8'h00;
    endcase
  endfunction

  assign step     = enable && (pre_cnt == LAST);
  // A load in the stepping cycle itself overrides any older pending request.
  assign req      = mode_load || mode_pending;
  assign req_mode = mode_load ? mode_t'(mode_in) : pend_q;
  assign pwm_on   = (duty == '1) || (pwm_cnt < duty);
  assign cur_mode = mode_q;

  always_comb begin
    adv_pat = pattern;
    adv_dir = dir;
    wrap    = 1'b0;
    case (mode_q)
      STATIC: adv_pat = 8'hFF;
      CHASE: begin
        adv_pat = {pattern[6:0], pattern[7]};
        wrap    = (pattern == 8'h80);
      end
      BOUNCE: begin
        if (dir == LEFT) begin
          if (pattern == 8'h80) begin
            adv_pat = 8'h40;
            adv_dir = RIGHT;
          end else begin
            adv_pat = pattern << 1;
          end
        end else begin
          if (pattern == 8'h01) begin
            adv_pat = 8'h02;
            adv_dir = LEFT;
          end else begin
            adv_pat = pattern >> 1;
          end
          wrap = (pattern == 8'h02);
        end
      end
      default: begin
        adv_pat = pattern + 8'd1;
        wrap    = (pattern == 8'hFF);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      pattern      <= 8'hFF;
      dir          <= LEFT;
      mode_q       <= STATIC;
      pend_q       <= STATIC;
      mode_pending <= 1'b0;
      step_tick    <= 1'b0;
      cycle_done   <= 1'b0;
      leds         <= '0;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      leds       <= pattern & {8{pwm_on}};
      step_tick  <= step;
      cycle_done <= 1'b0;

      if (enable) pre_cnt <= step ? '0 : pre_cnt + 1'b1;

      if (step) begin
        mode_pending <= 1'b0;
        if (req) begin
          mode_q  <= req_mode;
          pattern <= start_val(req_mode);
          dir     <= LEFT;
        end else begin
          pattern    <= adv_pat;
          dir        <= adv_dir;
          cycle_done <= wrap;
        end
      end else if (mode_load) begin
        pend_q       <= mode_t'(mode_in);
        mode_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer (STEP_DIV=4).
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable;
  logic [1:0] mode_in;
  logic       mode_load;
  logic [3:0] duty;
  logic [7:0] leds;
  logic       step_tick, cycle_done, mode_pending;
  logic [1:0] cur_mode;

  int total = 0;
  int bad   = 0;

  led_pattern_sequencer #(.STEP_DIV(4), .PWM_BITS(4)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .mode_in(mode_in),
    .mode_load(mode_load), .duty(duty), .leds(leds), .step_tick(step_tick),
    .cycle_done(cycle_done), .cur_mode(cur_mode), .mode_pending(mode_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until step_tick is seen, bounded to a few prescaler periods.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step_tick && n < 16);
    chk({tag, "_tick"}, 32'(step_tick), 32'd1);
  endtask

  task automatic load_apply(input logic [1:0] m, input string tag);
    mode_in   = m;
    mode_load = 1'b1;
    cyc();
    mode_load = 1'b0;
    if (!step_tick) wait_tick(tag);
    chk({tag, "_mode"}, 32'(cur_mode), 32'(m));
    chk({tag, "_pend"}, 32'(mode_pending), 32'd0);
  endtask

  logic [7:0] bexp [15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  initial begin
    int on_cnt;
    rstn = 1'b0; enable = 1'b1; mode_in = 2'd0; mode_load = 1'b0; duty = 4'd15;

    // 1: reset values, static pattern, tick every 4 cycles
    repeat (3) cyc();
    chk("rst_leds", 32'(leds), 32'h00);
    chk("rst_mode", 32'(cur_mode), 32'd0);
    chk("rst_tick", 32'(step_tick), 32'd0);
    chk("rst_pend", 32'(mode_pending), 32'd0);
    rstn = 1'b1;
    cyc(); chk("t1_tick1", 32'(step_tick), 32'd0);
    cyc(); chk("t1_tick2", 32'(step_tick), 32'd0);
    chk("t1_leds_ff", 32'(leds), 32'hFF);
    cyc(); chk("t1_tick3", 32'(step_tick), 32'd0);
    cyc(); chk("t1_tick4", 32'(step_tick), 32'd1);
    chk("t1_done", 32'(cycle_done), 32'd0);
    chk("t1_leds_static", 32'(leds), 32'hFF);
    cyc(); chk("t1_tick5", 32'(step_tick), 32'd0);

    // 2: chase via pending request
    mode_in = 2'd1; mode_load = 1'b1;
    cyc();
    mode_load = 1'b0;
    chk("t2_pend", 32'(mode_pending), 32'd1);
    chk("t2_mode_old", 32'(cur_mode), 32'd0);
    wait_tick("t2_apply");
    chk("t2_mode", 32'(cur_mode), 32'd1);
    chk("t2_pend_clr", 32'(mode_pending), 32'd0);
    chk("t2_done_chg", 32'(cycle_done), 32'd0);
    cyc(); chk("t2_leds0", 32'(leds), 32'h01);
    for (int k = 1; k <= 8; k++) begin
      wait_tick("t2_step");
      chk($sformatf("t2_done%0d", k), 32'(cycle_done), 32'(k == 8));
      cyc();
      chk($sformatf("t2_leds%0d", k), 32'(leds), 32'(8'h01 << (k % 8)));
    end

    // 3: bounce, 14-step period
    load_apply(2'd2, "t3_load");
    cyc(); chk("t3_leds0", 32'(leds), 32'(bexp[0]));
    for (int k = 1; k <= 14; k++) begin
      wait_tick("t3_step");
      chk($sformatf("t3_done%0d", k), 32'(cycle_done), 32'(k == 14));
      cyc();
      chk($sformatf("t3_leds%0d", k), 32'(leds), 32'(bexp[k]));
    end

    // 4: count with a freeze window
    load_apply(2'd3, "t4_load");
    for (int k = 1; k <= 5; k++) wait_tick("t4_pre");
    cyc();
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("t4_frz_tick", 32'(step_tick), 32'd0);
      chk("t4_frz_leds", 32'(leds), 32'h05);
    end
    enable = 1'b1;
    cyc(); chk("t4_rs_tick1", 32'(step_tick), 32'd0);
    cyc(); chk("t4_rs_tick2", 32'(step_tick), 32'd0);
    cyc(); chk("t4_rs_tick3", 32'(step_tick), 32'd1);
    for (int k = 7; k <= 256; k++) begin
      wait_tick("t4_run");
      if (k == 255 || k == 256) chk($sformatf("t4_done%0d", k), 32'(cycle_done), 32'(k == 256));
    end
    cyc(); chk("t4_wrap_leds", 32'(leds), 32'h00);

    // 5: PWM duty
    load_apply(2'd0, "t5_load");
    duty = 4'd4;
    repeat (3) cyc();
    on_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      if (leds == 8'hFF) on_cnt++;
      else chk("t5_off_val", 32'(leds), 32'h00);
      cyc();
    end
    chk("t5_on_cnt", 32'(on_cnt), 32'd8);
    duty = 4'd0;
    repeat (2) cyc();
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (leds != 8'h00) on_cnt++;
      cyc();
    end
    chk("t5_duty0", 32'(on_cnt), 32'd0);
    duty = 4'd15;

    // 6: last-wins request plus coincident load on the tick
    wait_tick("t6_align");
    mode_in = 2'd2; mode_load = 1'b1;
    cyc();
    mode_in = 2'd3;
    cyc();
    mode_load = 1'b0;
    chk("t6_pend", 32'(mode_pending), 32'd1);
    cyc();
    mode_in = 2'd1; mode_load = 1'b1;
    cyc();
    mode_load = 1'b0;
    chk("t6_tick", 32'(step_tick), 32'd1);
    chk("t6_mode", 32'(cur_mode), 32'd1);
    chk("t6_pend_clr", 32'(mode_pending), 32'd0);
    chk("t6_done", 32'(cycle_done), 32'd0);
    cyc(); chk("t6_leds", 32'(leds), 32'h01);
    for (int k = 1; k <= 3; k++) wait_tick("t6_chase");
    cyc(); chk("t6_leds3", 32'(leds), 32'h08);

    // async reset mid-chase, checked before any further clock edge
    #1 rstn = 1'b0;
    #1;
    chk("t6_arst_leds", 32'(leds), 32'h00);
    chk("t6_arst_mode", 32'(cur_mode), 32'd0);
    chk("t6_arst_tick", 32'(step_tick), 32'd0);
    cyc();
    rstn = 1'b1;
    cyc(); cyc();
    chk("t6_post_leds", 32'(leds), 32'hFF);
    chk("t6_post_mode", 32'(cur_mode), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Drives the 8 board LEDs (LED0..LED7, bus bit i = LEDi) with time-sequenced patterns instead of constant levels. A prescaler produces a step tick. A pattern engine advances once per tick in one of four modes. A 4-bit PWM stage applies global brightness before the registered LED outputs. It sits between the top-level pin assignments and any user/control logic that selects modes.

Parameters:
STEP_DIV, 1200000, clock cycles per pattern step (10 Hz at 12 MHz); legal range 2..2^24
PWM_BITS, 4, width of brightness duty and PWM counter

Ports:
clk  input  1  system clock (12 MHz on board)
rstn  input  1  asynchronous active-low reset
enable  input  1  1 = prescaler and pattern run; 0 = freeze (PWM keeps running)
mode_in  input  2  requested mode: 0 STATIC, 1 CHASE, 2 BOUNCE, 3 COUNT
mode_load  input  1  one-cycle strobe; captures mode_in as a pending request
duty  input  PWM_BITS  brightness; 0 = off, 2^PWM_BITS-1 = fully on
leds  output  8  registered LED drive, bit i to LEDi
step_tick  output  1  one-cycle pulse on each pattern step
cycle_done  output  1  one-cycle pulse when a pattern wraps to its start value
cur_mode  output  2  mode currently applied
mode_pending  output  1  a loaded mode is waiting for the next step

Behaviour:
- Async reset (rstn=0), all registers: leds=8'h00, step_tick=0, cycle_done=0, cur_mode=0 (STATIC), mode_pending=0, pattern=8'hFF, bounce dir=left, prescaler=0, PWM counter=0.
- Prescaler:
  - Counts 0..STEP_DIV-1 only while enable=1; holds its value while enable=0.
  - step_tick=1 for exactly the cycle after the count equals STEP_DIV-1; count wraps to 0.
  - Pattern, mode and cycle_done update in the same edge that raises step_tick.
- Mode request:
  - mode_load=1 sets the pending mode to mode_in and mode_pending=1. A later load before the tick overwrites it (last wins).
  - On a step, if a request is pending (including a mode_load in that same cycle, which takes priority), cur_mode takes the pending mode and pattern loads that mode's start value with no advance. mode_pending clears on that step.
  - Reloading the current mode restarts its pattern.
  - A request made while enable=0 stays pending until a step occurs.
- Start values / advance per step:
  - STATIC: 8'hFF, never changes.
  - CHASE: 8'h01, rotate left; 8'h80 goes to 8'h01.
  - BOUNCE: 8'h01 with dir=left; shift in dir. At 8'h80 the next value is 8'h40 and dir=right. At 8'h01 the next value is 8'h02 and dir=left. Period is 14 steps.
  - COUNT: 8'h00, +1 mod 256.
- cycle_done: pulses with step_tick when the advance produces the start value: CHASE 80->01, BOUNCE 02->01, COUNT FF->00. Never in STATIC; never on a mode-change step.
- PWM:
  - Free-running PWM_BITS counter, every cycle, independent of enable.
  - pwm_on = (duty == all-ones) or (cnt < duty).
  - leds <= pattern & {8{pwm_on}}, with one cycle of latency from pattern/counter to pins.
  - duty=0 gives leds constantly 0.
- A reset mid-pattern aborts immediately to the reset values. There is no partial step.

Test Plan:
1. Reset, STEP_DIV=4, enable=1, duty=15, no loads -> leds=8'h00 during reset, then 8'hFF from the second cycle after release. step_tick every 4 cycles; cycle_done never.
2. mode_load with mode_in=1 -> mode_pending=1 until the next tick, then cur_mode=1 and leds=01. After 8 further ticks leds=01 again with cycle_done on the 8th; mode_pending returns to 0.
3. BOUNCE mode, count 14 ticks -> leds sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01; cycle_done only on the final 02->01.
4. COUNT mode, enable low for 20 cycles mid-run -> leds and prescaler frozen, no step_tick. After 256 enabled ticks the value returns to 00 with cycle_done.
5. duty=4 in STATIC mode -> leds=FF for exactly 4 of every 16 cycles, 00 otherwise. With duty=0, leds=00 for all cycles.
6. mode_load(2) followed by mode_load(3) before a tick, then mode_load(1) coincident with the tick -> cur_mode=1 and pattern=01 on that tick. In a separate run, rstn pulsed low mid-CHASE -> leds=00, cur_mode=0, pattern FF, immediately and asynchronously.
